reset_release_sequencer: RTL and testbench

Downstream companion to the fabric reset controller. Consumes its fabric reset output and releases a configurable number of reset domains (e.g. interconnect, peripherals, processor core) one after another with fixed cycle gaps. Also supports a debug hold on the last stage (processor core) and a four-phase software soft-reset handshake. Sits between the fabric reset controller and the processor subsystem in the top-level design.

---
 rtl/reset_seq_pkg.sv | 26 ++
 rtl/reset_release_sequencer_reset_sync.sv | 25 ++
 rtl/reset_release_sequencer.sv | 146 ++++++++++++++
 tb/tb_reset_release_sequencer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the reset release sequencer.
package reset_seq_pkg;

    // Sequencer FSM states
    typedef enum logic [2:0] {
        IDLE,
        GAP,
        RUN,
        SOFT,
        WAIT_REL
    } seq_state_t;

    // Upper bound on the number of sequenced reset domains
    localparam int MAX_STAGES = 8;

    // Width of the stage index register; sized for the largest legal stage count
    localparam int IDX_W = $clog2(MAX_STAGES);

    // Counter width large enough to hold the longer of the two timed intervals
    function automatic int cnt_width(input int gap, input int hold);
        int longest;
        longest = (gap > hold) ? gap : hold;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/reset_release_sequencer_reset_sync.sv
// Two-flop reset synchronizer: the reset asserts asynchronously and is
// released only after two clean CLK edges.
module reset_sync (
    input  logic CLK,
    input  logic FABRIC_RESET_N,
    output logic rst_sync
);

    logic meta_reg;
    logic sync_reg;

    // Async assert, two-stage synchronous deassert
    always_ff @(posedge CLK or negedge FABRIC_RESET_N) begin
        if (!FABRIC_RESET_N) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
        end else begin
            meta_reg <= 1'b1;
            sync_reg <= meta_reg;
        end
    end

    assign rst_sync = sync_reg;

endmodule

// File: rtl/reset_release_sequencer.sv
// Reset release sequencer: releases NUM_STAGES reset domains one after
// another, STAGE_GAP cycles apart, with a debug hold on the last stage.
// Optional soft-reset handshake is built when RESET_SEQ_SOFT_RST_EN is defined.
module reset_release_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int STAGE_GAP  = 16,
    parameter int SOFT_HOLD  = 32
) (
    input  logic                  CLK,
    input  logic                  FABRIC_RESET_N,
    input  logic                  CPU_HOLD,
    input  logic                  SOFT_RST_REQ,
    output logic                  SOFT_RST_ACK,
    output logic [NUM_STAGES-1:0] RST_N,
    output logic                  SEQ_DONE
);

    localparam int                CNT_W    = cnt_width(STAGE_GAP, SOFT_HOLD);
    localparam logic [CNT_W-1:0]  GAP_LAST = CNT_W'(STAGE_GAP - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_STAGES - 1);
`ifdef RESET_SEQ_SOFT_RST_EN
    localparam logic [CNT_W-1:0]  SOFT_LAST = CNT_W'(SOFT_HOLD - 1);
`endif

    logic                  rst_sync;
    seq_state_t            state_reg;
    logic [CNT_W-1:0]      cnt_reg;
    logic [IDX_W-1:0]      idx_reg;
    logic [NUM_STAGES-1:0] rst_n_reg;
    logic                  done_reg;
    // Previous CPU_HOLD sample; keeps the counter parked for the edge that
    // first sees the hold low, so the last stage gets a full STAGE_GAP window
    logic                  hold_q_reg;
`ifdef RESET_SEQ_SOFT_RST_EN
    logic                  ack_reg;
`endif

    reset_sync u_reset_sync (
        .CLK            (CLK),
        .FABRIC_RESET_N (FABRIC_RESET_N),
        .rst_sync       (rst_sync)
    );

    // Sequencer FSM; every output is a flop cleared by the synchronized reset
    always_ff @(posedge CLK or negedge rst_sync) begin
        if (!rst_sync) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            idx_reg    <= '0;
            rst_n_reg  <= '0;
            done_reg   <= 1'b0;
            hold_q_reg <= 1'b0;
`ifdef RESET_SEQ_SOFT_RST_EN
            ack_reg    <= 1'b0;
`endif
        end else begin
            hold_q_reg <= CPU_HOLD;
            case (state_reg)
                IDLE: begin
                    state_reg <= GAP;
                    idx_reg   <= '0;
                    cnt_reg   <= '0;
                end

                GAP: begin
                    if ((idx_reg == LAST_IDX) && (CPU_HOLD || hold_q_reg)) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == GAP_LAST) begin
                        cnt_reg <= '0;
                        for (int k = 0; k < NUM_STAGES; k++) begin
                            if (idx_reg == IDX_W'(k)) begin
                                rst_n_reg[k] <= 1'b1;
                            end
                        end
                        if (idx_reg == LAST_IDX) begin
                            state_reg <= RUN;
                            done_reg  <= 1'b1;
                        end else begin
                            idx_reg <= idx_reg + 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                RUN: begin
`ifdef RESET_SEQ_SOFT_RST_EN
                    if (SOFT_RST_REQ) begin
                        rst_n_reg <= '0;
                        done_reg  <= 1'b0;
                        ack_reg   <= 1'b1;
                        cnt_reg   <= '0;
                        state_reg <= SOFT;
                    end else
`endif
                    if (CPU_HOLD) begin
                        rst_n_reg[NUM_STAGES-1] <= 1'b0;
                        done_reg  <= 1'b0;
                        idx_reg   <= LAST_IDX;
                        cnt_reg   <= '0;
                        state_reg <= GAP;
                    end
                end

`ifdef RESET_SEQ_SOFT_RST_EN
                SOFT: begin
                    if (cnt_reg == SOFT_LAST) begin
                        cnt_reg   <= '0;
                        state_reg <= WAIT_REL;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                WAIT_REL: begin
                    if (!SOFT_RST_REQ) begin
                        ack_reg   <= 1'b0;
                        idx_reg   <= '0;
                        cnt_reg   <= '0;
                        state_reg <= GAP;
                    end
                end
`endif

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign RST_N    = rst_n_reg;
    assign SEQ_DONE = done_reg;

`ifdef RESET_SEQ_SOFT_RST_EN
    assign SOFT_RST_ACK = ack_reg;
`else
    // Soft-reset request has no effect in this build
    logic unused_soft_req;
    assign unused_soft_req = SOFT_RST_REQ;
    assign SOFT_RST_ACK    = 1'b0;
`endif

endmodule

// File: tb/tb_reset_release_sequencer.sv
// Directed bench for reset_release_sequencer (NUM_STAGES=3, STAGE_GAP=4,
// SOFT_HOLD=8). Soft-reset steps follow RESET_SEQ_SOFT_RST_EN.
module tb_reset_release_sequencer;

    logic       clk;
    logic       fabric_reset_n;
    logic       cpu_hold;
    logic       soft_rst_req;
    logic       soft_rst_ack;
    logic [2:0] rst_n;
    logic       seq_done;

    int checks = 0;
    int errors = 0;

    reset_release_sequencer #(
        .NUM_STAGES (3),
        .STAGE_GAP  (4),
        .SOFT_HOLD  (8)
    ) dut (
        .CLK            (clk),
        .FABRIC_RESET_N (fabric_reset_n),
        .CPU_HOLD       (cpu_hold),
        .SOFT_RST_REQ   (soft_rst_req),
        .SOFT_RST_ACK   (soft_rst_ack),
        .RST_N          (rst_n),
        .SEQ_DONE       (seq_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle on the following falling edge
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [2:0] exp_rst,
                       input logic exp_done, input logic exp_ack);
        checks++;
        assert (rst_n === exp_rst) else begin
            errors++;
            $error("FAIL %s RST_N observed %b expected %b", tag, rst_n, exp_rst);
        end
        checks++;
        assert (seq_done === exp_done) else begin
            errors++;
            $error("FAIL %s SEQ_DONE observed %b expected %b", tag, seq_done, exp_done);
        end
        checks++;
        assert (soft_rst_ack === exp_ack) else begin
            errors++;
            $error("FAIL %s SOFT_RST_ACK observed %b expected %b", tag, soft_rst_ack, exp_ack);
        end
        $display("check %-16s RST_N=%b DONE=%b ACK=%b", tag, rst_n, seq_done, soft_rst_ack);
    endtask

    initial begin
        fabric_reset_n = 1'b0;
        cpu_hold       = 1'b0;
        soft_rst_req   = 1'b0;

        // Power-up: reset held 10 cycles, then released; S is 2 edges later
        step(10);
        chk("por_hold", 3'b000, 1'b0, 1'b0);
        fabric_reset_n = 1'b1;
        step(2);
        chk("por_S", 3'b000, 1'b0, 1'b0);
        step(4);
        chk("por_S+4", 3'b000, 1'b0, 1'b0);
        step(1);
        chk("por_S+5", 3'b001, 1'b0, 1'b0);
        step(3);
        chk("por_S+8", 3'b001, 1'b0, 1'b0);
        step(1);
        chk("por_S+9", 3'b011, 1'b0, 1'b0);
        step(3);
        chk("por_S+12", 3'b011, 1'b0, 1'b0);
        step(1);
        chk("por_S+13", 3'b111, 1'b1, 1'b0);
        step(5);
        chk("por_run", 3'b111, 1'b1, 1'b0);

        // Mid-sequence fabric reset: outputs clear without waiting for a clock
        fabric_reset_n = 1'b0;
        step(2);
        fabric_reset_n = 1'b1;
        step(2);
        step(9);
        chk("mid_S+9", 3'b011, 1'b0, 1'b0);
        #2 fabric_reset_n = 1'b0;
        #1;
        chk("mid_async", 3'b000, 1'b0, 1'b0);
        step(3);
        chk("mid_hold", 3'b000, 1'b0, 1'b0);
        fabric_reset_n = 1'b1;
        step(2);
        step(5);
        chk("mid_re_S+5", 3'b001, 1'b0, 1'b0);
        step(8);
        chk("mid_re_S+13", 3'b111, 1'b1, 1'b0);

        // Debug hold from power-up: last stage parked until CPU_HOLD drops
        fabric_reset_n = 1'b0;
        cpu_hold       = 1'b1;
        step(3);
        fabric_reset_n = 1'b1;
        step(2);
        step(9);
        chk("hold_S+9", 3'b011, 1'b0, 1'b0);
        step(20);
        chk("hold_parked", 3'b011, 1'b0, 1'b0);
        cpu_hold = 1'b0;
        step(1);
        chk("hold_H", 3'b011, 1'b0, 1'b0);
        step(3);
        chk("hold_H+3", 3'b011, 1'b0, 1'b0);
        step(1);
        chk("hold_H+4", 3'b111, 1'b1, 1'b0);

        // Debug hold re-asserted in RUN
        cpu_hold = 1'b1;
        step(1);
        chk("hold_run", 3'b011, 1'b0, 1'b0);
        step(5);
        chk("hold_run_park", 3'b011, 1'b0, 1'b0);
        cpu_hold = 1'b0;
        step(4);
        chk("hold_rel_H+3", 3'b011, 1'b0, 1'b0);
        step(1);
        chk("hold_rel_H+4", 3'b111, 1'b1, 1'b0);

`ifdef RESET_SEQ_SOFT_RST_EN
        // Soft reset with a 20-cycle request
        soft_rst_req = 1'b1;
        step(1);
        chk("soft_T", 3'b000, 1'b0, 1'b1);
        step(19);
        chk("soft_T+19", 3'b000, 1'b0, 1'b1);
        soft_rst_req = 1'b0;
        step(1);
        chk("soft_ackdrop", 3'b000, 1'b0, 1'b0);
        step(3);
        chk("soft_rel+3", 3'b000, 1'b0, 1'b0);
        step(1);
        chk("soft_rel+4", 3'b001, 1'b0, 1'b0);
        step(4);
        chk("soft_rel+8", 3'b011, 1'b0, 1'b0);
        step(4);
        chk("soft_rel+12", 3'b111, 1'b1, 1'b0);

        // Short 2-cycle request: SOFT_HOLD still enforced
        soft_rst_req = 1'b1;
        step(1);
        chk("short_T", 3'b000, 1'b0, 1'b1);
        step(1);
        soft_rst_req = 1'b0;
        step(7);
        chk("short_T+8", 3'b000, 1'b0, 1'b1);
        step(1);
        chk("short_T+9", 3'b000, 1'b0, 1'b0);
        step(3);
        chk("short_T+12", 3'b000, 1'b0, 1'b0);
        step(1);
        chk("short_T+13", 3'b001, 1'b0, 1'b0);
        step(8);
        chk("short_T+21", 3'b111, 1'b1, 1'b0);
`else
        // Soft reset disabled: request in RUN has no effect
        soft_rst_req = 1'b1;
        step(1);
        chk("nosoft_T", 3'b111, 1'b1, 1'b0);
        step(10);
        chk("nosoft_T+10", 3'b111, 1'b1, 1'b0);
        soft_rst_req = 1'b0;
        step(2);
        chk("nosoft_after", 3'b111, 1'b1, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
